// File: rtl/fns_serial_dec.sv
// fns_serial_dec: serial FNS/CAC codeword decoder, one 4-bit group per cycle.
// Define FNS_SERIAL_OVF_CHK_EN to build carry-out detection driving ovf.
module fns_serial_dec #(
   parameter int CW = 16,
   parameter int DW = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] codein,
   input  logic [CW-1:0] en_flag,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] dataout,
   output logic          ovf
);

   localparam int NG = CW / 4;
   localparam int GW = (NG > 1) ? $clog2(NG) : 1;
`ifdef FNS_SERIAL_OVF_CHK_EN
   localparam int XW = DW + 3;
`else
   localparam int XW = DW;
`endif

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [GW-1:0] G_LAST = GW'(NG - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] sr_q, sr_d;
   logic [DW-1:0] acc_q, acc_d;
   logic [DW-1:0] fa_q, fa_d;
   logic [DW-1:0] fb_q, fb_d;
   logic [GW-1:0] g_q, g_d;

   logic [3:0]    b;
   logic [XW-1:0] fa_x, fb_x, w2_x, w3_x;
   logic [XW-1:0] gsum_x, acc_x, nfa_x, nfb_x;

   // Extended width keeps every carry of the group sum and weight update.
   assign b      = sr_q[3:0];
   assign fa_x   = XW'(fa_q);
   assign fb_x   = XW'(fb_q);
   assign w2_x   = fa_x + fb_x;
   assign w3_x   = w2_x + fb_x;
   assign gsum_x = ({XW{b[0]}} & fa_x)
                 + ({XW{b[1]}} & fb_x)
                 + ({XW{b[2]}} & w2_x)
                 + ({XW{b[3]}} & w3_x);
   assign acc_x  = XW'(acc_q) + gsum_x;
   assign nfa_x  = w2_x + w3_x;
   assign nfb_x  = nfa_x + w3_x;

`ifdef FNS_SERIAL_OVF_CHK_EN
   logic ovf_q, ovf_d;
   logic carry;

   assign carry = |{acc_x[XW-1:DW], nfa_x[XW-1:DW], nfb_x[XW-1:DW]};
   assign ovf   = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign dataout   = acc_q;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      acc_d   = acc_q;
      fa_d    = fa_q;
      fb_d    = fb_q;
      g_d     = g_q;
`ifdef FNS_SERIAL_OVF_CHK_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = RUN;
               sr_d    = codein & en_flag;
               acc_d   = '0;
               fa_d    = DW'(1);
               fb_d    = DW'(1);
               g_d     = '0;
`ifdef FNS_SERIAL_OVF_CHK_EN
               ovf_d   = 1'b0;
`endif
            end
         end
         RUN: begin
            sr_d  = sr_q >> 4;
            acc_d = acc_x[DW-1:0];
            fa_d  = nfa_x[DW-1:0];
            fb_d  = nfb_x[DW-1:0];
            g_d   = g_q + 1'b1;
`ifdef FNS_SERIAL_OVF_CHK_EN
            ovf_d = ovf_q | carry;
`endif
            if (g_q == G_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         acc_q   <= '0;
         fa_q    <= DW'(1);
         fb_q    <= DW'(1);
         g_q     <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         acc_q   <= acc_d;
         fa_q    <= fa_d;
         fb_q    <= fb_d;
         g_q     <= g_d;
      end
   end

`ifdef FNS_SERIAL_OVF_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end
`endif

endmodule

// File: tb/tb_fns_serial_dec.sv
// tb_fns_serial_dec: scoreboard bench for fns_serial_dec.
// Expected values come from a direct Fibonacci-sum reference.
module tb_fns_serial_dec;

   localparam int CW = 16;
   localparam int DW = 12;
`ifdef FNS_SERIAL_OVF_CHK_EN
   localparam bit OVF = 1'b1;
`else
   localparam bit OVF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready, ovf;
   logic [CW-1:0] codein, en_flag;
   logic [DW-1:0] dataout;

   logic          in8_valid, in8_ready, out8_valid, out8_ready, ovf8;
   logic [15:0]   code8, en8;
   logic [7:0]    data8;

   always #5 clk = ~clk;

   fns_serial_dec #(.CW(CW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .codein(codein), .en_flag(en_flag),
      .out_valid(out_valid), .out_ready(out_ready),
      .dataout(dataout), .ovf(ovf)
   );

   fns_serial_dec #(.CW(16), .DW(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in8_valid), .in_ready(in8_ready),
      .codein(code8), .en_flag(en8),
      .out_valid(out8_valid), .out_ready(out8_ready),
      .dataout(data8), .ovf(ovf8)
   );

   typedef struct {
      longint d;
      bit     o;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   bit   ov_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] c, input int dw);
      longint f[18];
      longint s;
      longint lim;
      exp_t   r;
      f[0] = 1;
      f[1] = 1;
      for (int i = 2; i < 18; i++) f[i] = f[i-1] + f[i-2];
      s = 0;
      for (int i = 0; i < 16; i++) if (c[i]) s += f[i];
      lim = longint'(1) << dw;
      r.d = s % lim;
      r.o = OVF && ((f[17] >= lim) || (s >= lim));
      return r;
   endfunction

   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (out_valid && !ov_prev) chk("latency", cyc - acc_cyc, CW / 4);
         ov_prev = out_valid;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_empty", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("data", dataout, e.d);
               chk("ovf", ovf, e.o);
            end
         end
      end
   end

   task automatic send(input logic [15:0] c, input logic [15:0] e);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("send_timeout", 0, 1);
      end else begin
         in_valid = 1'b1;
         codein   = c;
         en_flag  = e;
         sb.push_back(model(c & e, DW));
         @(posedge clk);
         #1;
         acc_cyc  = cyc;
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_ov();
      int n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) chk("ov_timeout", 0, 1);
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", sb.size(), 0);
   endtask

   initial begin : wdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin : main
      logic [15:0]   rc, re;
      logic [DW-1:0] d0;
      exp_t          e8;
      int            n;

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      codein     = '0;
      en_flag    = '0;
      out_ready  = 1'b1;
      in8_valid  = 1'b0;
      code8      = '0;
      en8        = '0;
      out8_ready = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dataout", dataout, 0);
      chk("rst_ovf", ovf, 0);
      rst_n = 1'b1;

      send(16'h0001, 16'hFFFF);
      send(16'h000F, 16'hFFFF);
      send(16'hFFFF, 16'hFFFF);
      send(16'hFFFF, 16'h00F0);
      send(16'h0000, 16'hFFFF);
      send(16'h8000, 16'hFFFF);
      for (int i = 0; i < 6; i++) begin
         rc = 16'($urandom);
         re = 16'($urandom);
         send(rc, re);
      end
      drain();

      out_ready = 1'b0;
      send(16'h0155, 16'hFFFF);
      wait_ov();
      d0       = dataout;
      in_valid = 1'b1;
      codein   = 16'hFFFF;
      en_flag  = 16'hFFFF;
      repeat (3) begin
         chk("bp_data", dataout, d0);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_rel_in_ready", in_ready, 1);
      chk("bp_rel_out_valid", out_valid, 0);
      drain();

      send(16'h00FF, 16'hFFFF);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_dataout", dataout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      send(16'h0003, 16'hFFFF);
      drain();

      @(negedge clk);
      in8_valid = 1'b1;
      code8     = 16'hFFFF;
      en8       = 16'hFFFF;
      @(posedge clk);
      #1;
      in8_valid = 1'b0;
      n = 0;
      while (!out8_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("dw8_valid", out8_valid, 1);
      e8 = model(16'hFFFF, 8);
      chk("dw8_data", data8, e8.d);
      chk("dw8_ovf", ovf8, e8.o);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
